// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: default widths, opcode map,
// instruction-register field positions and the fetch-state encoding.
package cpu_pkg;

  localparam int          DEF_ADDR_W   = 8;
  localparam int          DEF_INSTR_W  = 8;
  localparam logic [7:0]  DEF_RESET_PC = 8'h00;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_LW  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;

  // Instruction layout: [7:4] opcode, [3:2] rd, [1:0] rs.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: holds the fetch address, advances by one (wrapping) or
// loads a branch target when enabled.
module pc_reg #(
  parameter int               ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (en) begin
      // branch_taken only matters when the PC is actually being written.
      pc <= branch_taken ? branch_target : pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: requests the word at pc, buffers it once returned, and loads
// the instruction register on IRWrite from the control FSM.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCWrite,
  input  logic               IRWrite,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic [3:0]         Opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic               ir_valid,
  output logic               fetch_stall
);

  fetch_state_t       state, next_state;
  logic               buf_load;
  logic               buf_full;
  logic [INSTR_W-1:0] fetch_buf;
  logic [INSTR_W-1:0] ir;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .en            (PCWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc)
  );

  assign buf_full  = (state == FETCH_HOLD);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_REQ;
    else     state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    buf_load   = 1'b0;
    imem_req   = 1'b0;
    case (state)
      FETCH_REQ: begin
        imem_req = !rst;
        // A PCWrite drops the outstanding request, including a same-cycle ready.
        if (!PCWrite && imem_ready) begin
          next_state = FETCH_HOLD;
          buf_load   = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (PCWrite) next_state = FETCH_REQ;
      end
      default: next_state = FETCH_REQ;
    endcase
  end

  // NOTE: the data buffer carries no reset; its contents are only consumed
  // while buf_full, which is itself reset.
  always_ff @(posedge clk) begin
    if (buf_load) fetch_buf <= imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir          <= '0;
      ir_valid    <= 1'b0;
      fetch_stall <= 1'b0;
    end else begin
      fetch_stall <= IRWrite && !buf_full;
      if (IRWrite && buf_full) begin
        ir       <= fetch_buf;
        ir_valid <= 1'b1;
      end
    end
  end

  assign Opcode = ir[OPC_MSB:OPC_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; instruction memory returns addr ^ 8'hA5.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       PCWrite, IRWrite, branch_taken;
  logic [7:0] branch_target;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ready;
  logic [7:0] pc;
  logic [3:0] Opcode;
  logic [1:0] rd, rs;
  logic       ir_valid, fetch_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 8'hA5;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IRWrite       (IRWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pc            (pc),
    .Opcode        (Opcode),
    .rd            (rd),
    .rs            (rs),
    .ir_valid      (ir_valid),
    .fetch_stall   (fetch_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ir(input string tag, input logic [3:0] op, input logic [1:0] erd,
                          input logic [1:0] ers);
    check({tag, ".op"}, 32'(Opcode), 32'(op));
    check({tag, ".rd"}, 32'(rd), 32'(erd));
    check({tag, ".rs"}, 32'(rs), 32'(ers));
  endtask

  initial begin
    rst = 1'b1; PCWrite = 1'b0; IRWrite = 1'b0; branch_taken = 1'b0;
    branch_target = 8'h00; imem_ready = 1'b1;

    // 1: reset with ready high (ignored), then first fetch and IR load.
    step(); step();
    check("rst.req", 32'(imem_req), 32'd0);
    check("rst.pc", 32'(pc), 32'h00);
    check("rst.valid", 32'(ir_valid), 32'd0);
    check("rst.stall", 32'(fetch_stall), 32'd0);
    check("rst.op", 32'(Opcode), 32'h0);
    rst = 1'b0;
    #1;
    check("t1.req", 32'(imem_req), 32'd1);
    check("t1.addr", 32'(imem_addr), 32'h00);
    step();
    check("t1.hold_req", 32'(imem_req), 32'd0);
    IRWrite = 1'b1; step(); IRWrite = 1'b0;
    check_ir("t1.ir", 4'hA, 2'd1, 2'd1);
    check("t1.valid", 32'(ir_valid), 32'd1);
    check("t1.stall", 32'(fetch_stall), 32'd0);

    // 2: memory not ready for 3 cycles; request held, IRWrite stalls.
    imem_ready = 1'b0;
    PCWrite = 1'b1; step(); PCWrite = 1'b0;
    check("t2.pc", 32'(pc), 32'h01);
    for (int i = 0; i < 3; i++) begin
      check("t2.req_held", 32'(imem_req), 32'd1);
      check("t2.addr_held", 32'(imem_addr), 32'h01);
      step();
    end
    IRWrite = 1'b1; step(); IRWrite = 1'b0;
    check("t2.stall", 32'(fetch_stall), 32'd1);
    check_ir("t2.ir_kept", 4'hA, 2'd1, 2'd1);
    step();
    check("t2.stall_drop", 32'(fetch_stall), 32'd0);
    // IRWrite on the same edge as imem_ready still stalls.
    imem_ready = 1'b1; IRWrite = 1'b1; step(); IRWrite = 1'b0;
    check("t2.same_edge_stall", 32'(fetch_stall), 32'd1);
    check_ir("t2.same_edge_ir", 4'hA, 2'd1, 2'd1);
    check("t2.now_hold", 32'(imem_req), 32'd0);
    // IRWrite+PCWrite together: IR gets the word at the old pc (01 -> A4).
    IRWrite = 1'b1; PCWrite = 1'b1; step(); IRWrite = 1'b0; PCWrite = 1'b0;
    check_ir("t2.ir_pc_same", 4'hA, 2'd1, 2'd0);
    check("t2.pc_adv", 32'(pc), 32'h02);
    check("t2.rereq", 32'(imem_req), 32'd1);

    // 4: branch, and branch_taken alone is ignored.
    imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 8'h40; PCWrite = 1'b1;
    step(); PCWrite = 1'b0;
    check("t4.addr", 32'(imem_addr), 32'h40);
    check("t4.req", 32'(imem_req), 32'd1);
    branch_target = 8'h80; step();
    check("t4.no_pcwrite", 32'(pc), 32'h40);

    // 3: increments from 00 and wrap from FF.
    branch_target = 8'h00; PCWrite = 1'b1; step();
    branch_taken = 1'b0;
    check("t3.pc0", 32'(pc), 32'h00);
    step(); check("t3.pc1", 32'(pc), 32'h01);
    step(); check("t3.pc2", 32'(pc), 32'h02);
    step(); check("t3.pc3", 32'(pc), 32'h03);
    branch_taken = 1'b1; branch_target = 8'hFF; step();
    branch_taken = 1'b0;
    check("t3.pcff", 32'(pc), 32'hFF);
    step(); PCWrite = 1'b0;
    check("t3.wrap", 32'(pc), 32'h00);

    // 5: PCWrite in REQ with ready high discards the returned word.
    imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h10; PCWrite = 1'b1;
    step(); PCWrite = 1'b0; branch_taken = 1'b0;
    check("t5.rereq", 32'(imem_req), 32'd1);
    check("t5.addr", 32'(imem_addr), 32'h10);
    IRWrite = 1'b1; step(); IRWrite = 1'b0;
    check("t5.empty_stall", 32'(fetch_stall), 32'd1);
    check_ir("t5.ir_kept", 4'hA, 2'd1, 2'd0);
    IRWrite = 1'b1; step(); IRWrite = 1'b0;
    check_ir("t5.ir_new", 4'hB, 2'd1, 2'd1);
    check("t5.stall_clr", 32'(fetch_stall), 32'd0);

    // 6: reset while a request is pending.
    imem_ready = 1'b0; PCWrite = 1'b1; step(); PCWrite = 1'b0;
    check("t6.pending", 32'(imem_req), 32'd1);
    check("t6.pc", 32'(pc), 32'h11);
    rst = 1'b1; imem_ready = 1'b1; step();
    check("t6.req", 32'(imem_req), 32'd0);
    check("t6.pc_rst", 32'(pc), 32'h00);
    check("t6.valid", 32'(ir_valid), 32'd0);
    check("t6.stall", 32'(fetch_stall), 32'd0);
    check_ir("t6.ir", 4'h0, 2'd0, 2'd0);
    rst = 1'b0; #1;
    check("t6.req_after", 32'(imem_req), 32'd1);
    check("t6.addr_after", 32'(imem_addr), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
